inject_queue: RTL and testbench
===============================

Name: inject_queue

Overview:
- Host-side injection buffer that sits directly upstream of a node's inject port.
- Accepts flits plus children counts from the host/PE with a valid/ready handshake and stores them in a FIFO.
- Presents one flit at a time on the node inject bus (flit bits plus children field), holding it until the node accepts it.
- Enforces a programmable idle gap between injected flits so the router ingress is never back-to-back saturated.

Parameters:
- FLIT_WIDTH, 82, flit width; the valid bit is FLIT_WIDTH-1 (bit 81).
- CHILDREN_WIDTH, 3, children field width (equals lg_numprocs).
- LG_DEPTH, 3, log2 of FIFO depth.
- DEPTH, 8, FIFO entries; must equal 1<<LG_DEPTH.
- MIN_GAP, 0, idle cycles forced on the inject bus after each accepted flit (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- host_flit  in  FLIT_WIDTH  flit from host; bit 81 ignored.
- host_children  in  CHILDREN_WIDTH  children count for this flit.
- host_valid  in  1  host offers a flit.
- host_ready  out  1  queue can accept; equals (count != DEPTH).
- node_ready  in  1  node accepts the presented flit this cycle.
- inject_out  out  FLIT_WIDTH+CHILDREN_WIDTH  [84:82]=children, [81]=valid, [80:0]=payload.
- count  out  LG_DEPTH+1  FIFO occupancy, 0..DEPTH; excludes the flit held in the output register.

Behaviour:
- Reset (rst low, async): FIFO pointers and count=0; inject_out=0; FSM=IDLE; gap counter=0; host_ready reads 1 once rst is released.
- Push: on an edge where host_valid && host_ready, write {host_children, host_flit[80:0]} at wptr; wptr wraps DEPTH-1 -> 0.
- Full FIFO: host_ready=0 even if a pop happens in the same cycle. No push at full, no bypass.
- Pop: occurs when the FSM loads the output register. rptr wraps DEPTH-1 -> 0.
- Simultaneous push and pop (not full): count is unchanged.
- Output register: inject_out[81]=1 whenever a flit is presented; inject_out is all-zero when no flit is presented.
- FSM states:
  - IDLE: if count>0, load the head into inject_out with bit81=1, pop, go to SEND.
  - SEND: hold inject_out stable while node_ready=0. On an edge with node_ready=1 the flit is consumed:
    - If MIN_GAP=0 and count>0, load the next flit on the same edge and stay in SEND. This gives back-to-back flits.
    - If MIN_GAP=0 and count=0, clear inject_out and go to IDLE.
    - If MIN_GAP>0, clear inject_out, load gap counter with MIN_GAP-1, go to GAP.
  - GAP: inject_out=0; decrement each cycle. When the counter is 0 and count>0, load the next flit and go to SEND; when the counter is 0 and count=0, go to IDLE.
- Latency: a flit pushed at edge t into an empty queue in IDLE appears on inject_out after edge t+1 (2 cycles push-to-present).
- node_ready is ignored in IDLE and GAP.
- Reset mid-operation: all queued and presented flits are dropped; inject_out clears immediately (asynchronous).
- Host payload bit 81 is never propagated; the valid bit is always generated internally.

Optional Feature:
- Macro: INJECT_STATS_EN.
- When defined, adds output ports:
  - inj_count (32 b): number of flits consumed by the node.
  - stall_cycles (32 b): cycles in SEND with node_ready=0.
  - Both reset to 0, saturate at all-ones, and do not wrap.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push flit payload 81'h1_2345 with children=3, node_ready=1 -> 2 cycles later inject_out=={3'd3,1'b1,81'h1_2345} for exactly 1 cycle; count returns to 0.
- Push 9 flits back-to-back with node_ready=0 -> host_ready drops after the 9th accept (1 presented, count=8); the 10th offer is not accepted; inject_out holds flit 1 stable.
- MIN_GAP=0, 4 queued flits, node_ready=1 -> 4 consecutive valid cycles in order, then inject_out=0.
- MIN_GAP=2, 3 queued flits, node_ready=1 -> valid/idle pattern 1,0,0,1,0,0,1, then 0.
- Push at count=7 while a pop occurs -> count stays 7; then full with a simultaneous pop -> push is refused; FIFO order preserved across pointer wrap (16 flits in, 16 out, identical order).
- Assert rst low while in SEND with count=5 -> inject_out=0 in the same cycle; after release count=0 and no stale flit appears; with INJECT_STATS_EN, inj_count=0.

Source files
------------

// File: rtl/inject_queue.sv
// -----------------------------------------------------------------------------
// inject_queue
//
// Host-side injection buffer placed directly upstream of a node's inject port.
// The host pushes flits (plus a children count) through a valid/ready
// handshake into an 8-deep FIFO. One flit at a time is presented on the node
// inject bus and held until the node accepts it. An optional programmable
// idle gap (MIN_GAP) is forced after every accepted flit so the router
// ingress never sees back-to-back traffic when that is undesirable.
//
// Optional build feature (macro INJECT_STATS_EN):
//   When defined, two saturating 32-bit statistics outputs are added:
//   inj_count (flits consumed by the node) and stall_cycles (cycles spent
//   presenting a flit while node_ready=0).
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-low reset
//   host_flit      in   FLIT_WIDTH     flit from host (valid bit position ignored)
//   host_children  in   CHILDREN_WIDTH children count for this flit
//   host_valid     in   host offers a flit
//   host_ready     out  queue can accept (count != DEPTH)
//   node_ready     in   node accepts the presented flit this cycle
//   inject_out     out  FLIT_WIDTH+CHILDREN_WIDTH {children, valid, payload}
//   count          out  LG_DEPTH+1     FIFO occupancy, excludes presented flit
//   inj_count      out  32 (INJECT_STATS_EN only)
//   stall_cycles   out  32 (INJECT_STATS_EN only)
// -----------------------------------------------------------------------------
module inject_queue #(
    parameter int FLIT_WIDTH     = 82,
    parameter int CHILDREN_WIDTH = 3,
    parameter int LG_DEPTH       = 3,
    parameter int DEPTH          = 8,
    parameter int MIN_GAP        = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [FLIT_WIDTH-1:0]                host_flit,
    input  logic [CHILDREN_WIDTH-1:0]            host_children,
    input  logic                                 host_valid,
    output logic                                 host_ready,
    input  logic                                 node_ready,
    output logic [FLIT_WIDTH+CHILDREN_WIDTH-1:0] inject_out,
    output logic [LG_DEPTH:0]                    count
`ifdef INJECT_STATS_EN
    ,
    output logic [31:0]                          inj_count,
    output logic [31:0]                          stall_cycles
`endif
);

    localparam int PAYLOAD_W = FLIT_WIDTH - 1;
    localparam int ENTRY_W   = CHILDREN_WIDTH + PAYLOAD_W;
    localparam int OUT_W     = FLIT_WIDTH + CHILDREN_WIDTH;

    localparam logic [LG_DEPTH:0] DEPTH_C  = (LG_DEPTH+1)'(DEPTH);
    // Gap counter preload; counts down to 0, so MIN_GAP idle cycles total.
    localparam int                GAP_LOAD_I = (MIN_GAP > 0) ? (MIN_GAP - 1) : 0;
    localparam logic [3:0]        GAP_LOAD   = 4'(GAP_LOAD_I);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // FIFO storage and pointers
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [LG_DEPTH-1:0] wptr_reg;
    logic [LG_DEPTH-1:0] rptr_reg;
    logic [LG_DEPTH:0]   count_reg;

    state_t              state_reg;
    state_t              state_next;
    logic [3:0]          gap_reg;
    logic [3:0]          gap_next;
    logic [OUT_W-1:0]    out_reg;

    logic                push;
    logic                load;      // pop head into the output register
    logic                clear;     // drop the presented flit after consumption
    logic                consume;   // node takes the presented flit
    logic                stall;     // flit presented but node not ready
    logic                nonempty;
    logic [ENTRY_W-1:0]  head;

    assign nonempty   = (count_reg != '0);
    // Full blocks pushes even when a pop happens on the same edge (no bypass).
    assign host_ready = (count_reg != DEPTH_C);
    assign push       = host_valid && host_ready;
    assign count      = count_reg;
    assign inject_out = out_reg;

    // The output register acts as the read register of the storage array,
    // so the head entry is read combinationally and captured on the pop edge.
    assign head = mem[rptr_reg];

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= {host_children, host_flit[PAYLOAD_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            // Pointers are LG_DEPTH wide and DEPTH is a power of two, so they
            // wrap from DEPTH-1 to 0 naturally.
            if (push) begin
                wptr_reg <= wptr_reg + LG_DEPTH'(1);
            end
            if (load) begin
                rptr_reg <= rptr_reg + LG_DEPTH'(1);
            end
            case ({push, load})
                2'b10:   count_reg <= count_reg + (LG_DEPTH+1)'(1);
                2'b01:   count_reg <= count_reg - (LG_DEPTH+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Inject FSM: state register (also holds gap counter and output register)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            gap_reg   <= '0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
            if (load) begin
                // Valid bit is always generated here; host bit is discarded.
                out_reg <= {head[ENTRY_W-1 -: CHILDREN_WIDTH], 1'b1,
                            head[PAYLOAD_W-1:0]};
            end else if (clear) begin
                out_reg <= '0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        case (state_reg)
            IDLE: begin
                if (nonempty) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (node_ready) begin
                    if (MIN_GAP == 0) begin
                        // Back-to-back: stay in SEND if another flit is queued.
                        if (!nonempty) begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = GAP;
                        gap_next   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_reg == 4'd0) begin
                    state_next = nonempty ? SEND : IDLE;
                end else begin
                    gap_next = gap_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gap_next   = '0;
            end
        endcase
    end

    // Output/control decode
    always_comb begin
        load    = 1'b0;
        clear   = 1'b0;
        consume = 1'b0;
        stall   = 1'b0;
        case (state_reg)
            IDLE: begin
                load = nonempty;
            end
            SEND: begin
                if (node_ready) begin
                    consume = 1'b1;
                    if ((MIN_GAP == 0) && nonempty) begin
                        load = 1'b1;
                    end else begin
                        clear = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            GAP: begin
                load = (gap_reg == 4'd0) && nonempty;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

`ifdef INJECT_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating statistics counters
    // -------------------------------------------------------------------------
    logic [31:0] inj_count_reg;
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_count_reg    <= '0;
            stall_cycles_reg <= '0;
        end else begin
            if (consume && (inj_count_reg != '1)) begin
                inj_count_reg <= inj_count_reg + 32'd1;
            end
            if (stall && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

    assign inj_count    = inj_count_reg;
    assign stall_cycles = stall_cycles_reg;
`else
    // Without statistics the consume strobe has no further use.
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_inject_queue.sv
// -----------------------------------------------------------------------------
// tb_inject_queue
//
// Directed bench for inject_queue. Two instances share the stimulus: one with
// MIN_GAP=0 (back-to-back) and one with MIN_GAP=2 (gap pattern). Outputs are
// sampled 1 time unit after the rising edge, inputs driven at the same point.
// -----------------------------------------------------------------------------
module tb_inject_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [81:0] host_flit;
    logic [2:0]  host_children;
    logic        host_valid;
    logic        node_ready;

    logic        host_ready0, host_ready2;
    logic [84:0] out0, out2;
    logic [3:0]  count0, count2;
`ifdef INJECT_STATS_EN
    logic [31:0] inj_count0, stall_cycles0, inj_count2, stall_cycles2;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    inject_queue #(.MIN_GAP(0)) dut0 (
        .clk           (clk),
        .rst           (rst),
        .host_flit     (host_flit),
        .host_children (host_children),
        .host_valid    (host_valid),
        .host_ready    (host_ready0),
        .node_ready    (node_ready),
        .inject_out    (out0),
        .count         (count0)
`ifdef INJECT_STATS_EN
        ,
        .inj_count     (inj_count0),
        .stall_cycles  (stall_cycles0)
`endif
    );

    inject_queue #(.MIN_GAP(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .host_flit     (host_flit),
        .host_children (host_children),
        .host_valid    (host_valid),
        .host_ready    (host_ready2),
        .node_ready    (node_ready),
        .inject_out    (out2),
        .count         (count2)
`ifdef INJECT_STATS_EN
        ,
        .inj_count     (inj_count2),
        .stall_cycles  (stall_cycles2)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload for flit k (81 bits); bit 81 of the host flit is toggled to
    // prove it never reaches the inject bus.
    function automatic logic [80:0] pay(input int k);
        return {1'b0, 64'hA5A5_0000_0000_5A5A, 16'(k)};
    endfunction

    function automatic logic [81:0] hflit(input int k);
        return {1'(k & 1), pay(k)};
    endfunction

    function automatic logic [84:0] exp_out(input int k);
        if (k == 0) return '0;
        return {3'(k), 1'b1, pay(k)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int k);
        host_flit     = hflit(k);
        host_children = 3'(k);
        host_valid    = 1'b1;
    endtask

    task automatic do_reset();
        host_valid = 1'b0;
        rst        = 1'b0;
        step();
        rst        = 1'b1;
    endtask

    int seq0 [11] = '{41, 42, 43, 44, 0, 0, 0, 0, 0, 0, 0};
    int seq2 [11] = '{41, 0, 0, 42, 0, 0, 43, 0, 0, 44, 0};

    initial begin
        rst           = 1'b0;
        host_flit     = '0;
        host_children = '0;
        host_valid    = 1'b0;
        node_ready    = 1'b0;
        step();
        step();

        // Reset state
        check("rst_out", out0, 0);
        check("rst_count", count0, 0);
        rst = 1'b1;
        check("rst_ready", host_ready0, 1);

        // Single flit, 2-cycle latency, one valid cycle
        host_flit     = {1'b1, 81'h1_2345};
        host_children = 3'd3;
        host_valid    = 1'b1;
        node_ready    = 1'b1;
        step();
        host_valid = 1'b0;
        check("t1_pushed_count", count0, 1);
        check("t1_not_yet", out0, 0);
        step();
        check("t1_present", out0, {3'd3, 1'b1, 81'h1_2345});
        check("t1_count0", count0, 0);
        step();
        check("t1_cleared", out0, 0);
`ifdef INJECT_STATS_EN
        check("t1_inj_count", inj_count0, 1);
`endif

        // Fill: 9 accepted, 10th refused, flit 1 held
        do_reset();
        node_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            offer(k);
            step();
        end
        check("fill_count", count0, 8);
        check("fill_ready", host_ready0, 0);
        check("fill_hold", out0, exp_out(1));
        offer(10);
        step();
        check("fill_refused_count", count0, 8);
        check("fill_hold2", out0, exp_out(1));

        // Drain one; then push at count=7 while popping
        host_valid = 1'b0;
        node_ready = 1'b1;
        step();
        check("drain_first", out0, exp_out(2));
        check("drain_count", count0, 7);
        offer(10);
        step();
        check("pushpop_count", count0, 7);
        check("pushpop_out", out0, exp_out(3));
        node_ready = 1'b0;
        offer(11);
        step();
        check("refill_count", count0, 8);
        check("refill_ready", host_ready0, 0);
        // Full with simultaneous pop: push refused, count drops
        node_ready = 1'b1;
        offer(12);
        step();
        host_valid = 1'b0;
        check("full_pop_count", count0, 7);
        check("full_pop_out", out0, exp_out(4));
        for (int k = 5; k <= 11; k++) begin
            step();
            check($sformatf("order_%0d", k), out0, exp_out(k));
        end
        step();
        check("order_end_out", out0, 0);
        check("order_end_count", count0, 0);

        // Pointer wrap: 16 flits streamed in, 16 out in order
        do_reset();
        node_ready = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            if (c <= 16) offer(c + 20);
            else         host_valid = 1'b0;
            step();
            if (c >= 2 && c <= 17) check($sformatf("wrap_%0d", c), out0, exp_out(c + 19));
            if (c == 18)           check("wrap_end", out0, 0);
        end

        // Back-to-back (MIN_GAP=0) vs gap pattern (MIN_GAP=2)
        do_reset();
        node_ready = 1'b0;
        for (int k = 41; k <= 44; k++) begin
            offer(k);
            step();
        end
        host_valid = 1'b0;
        check("gap_count0", count0, 3);
        check("gap_count2", count2, 3);
        node_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("b2b_%0d", i), out0, exp_out(seq0[i]));
            check($sformatf("gap2_%0d", i), out2, exp_out(seq2[i]));
            step();
        end

        // Reset mid-operation with count=5
        do_reset();
        node_ready = 1'b0;
        for (int k = 51; k <= 56; k++) begin
            offer(k);
            step();
        end
        host_valid = 1'b0;
        check("mid_count", count0, 5);
        check("mid_out", out0, exp_out(51));
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out0", out0, 0);
        check("mid_rst_out2", out2, 0);
        check("mid_rst_count", count0, 0);
        step();
        rst        = 1'b1;
        node_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_rst_out_%0d", i), out0, 0);
            check($sformatf("post_rst_count_%0d", i), count0, 0);
        end
`ifdef INJECT_STATS_EN
        check("post_rst_inj_count", inj_count0, 0);
        check("post_rst_stall", stall_cycles0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
